// File: rtl/gpmc_sync_initiator.sv
// Synchronous muxed-AD GPMC initiator on a clk/2 forwarded clock.
// Optional responder stall support is enabled with `define GPMC_INIT_WAIT_EN.
module gpmc_sync_initiator #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_CYCLES = 2,
  parameter int unsigned DATA_CYCLES = 2,
  parameter int unsigned RD_WAIT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  wr_done,
  output logic                  gpmc_clk,
  output logic                  gpmc_cs_n,
  output logic                  gpmc_adv_n,
  output logic                  gpmc_we_n,
  output logic                  gpmc_oe_n,
  output logic [15:0]           gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic [15:0]           gpmc_ad_in,
  input  logic                  gpmc_wait
);

  typedef enum logic [2:0] {StIdle, StAddr, StWdata, StRdata, StTurn} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            limit_m1;
  logic                  gclk_q;
  logic                  fall_tick, hs, last, stall, rd_sample;
  logic                  rd_done_q, rd_done_d;
  logic                  write_q, write_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [15:0]           addr_ext, wdata_ext;
  logic                  cs_n_d, adv_n_d, we_n_d, oe_n_d, ad_oe_d;
  logic [15:0]           ad_out_d;
  logic                  cs_n_q, adv_n_q, we_n_q, oe_n_q, ad_oe_q;
  logic [15:0]           ad_out_q;
  logic                  rsp_valid_q, wr_done_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  stall_seen;

  // A clk edge taken while gpmc_clk is high is the falling gpmc edge.
  assign fall_tick = gclk_q;
  assign req_ready = gclk_q && (state_q == StIdle || state_q == StTurn);
  assign hs        = req_valid && req_ready;

`ifdef GPMC_INIT_WAIT_EN
  logic wait_s1_q, wait_s2_q, stall_seen_q;
  assign stall = fall_tick && wait_s2_q && (state_q == StWdata || state_q == StRdata);
  assign stall_seen = stall_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_s1_q    <= 1'b0;
      wait_s2_q    <= 1'b0;
      stall_seen_q <= 1'b0;
    end else begin
      wait_s1_q <= gpmc_wait;
      wait_s2_q <= wait_s1_q;
      if (fall_tick) stall_seen_q <= stall;
    end
  end
`else
  logic unused_wait;
  assign unused_wait = gpmc_wait;
  assign stall       = 1'b0;
  assign stall_seen  = 1'b0;
`endif

  always_comb begin
    limit_m1 = 8'd0;
    unique case (state_q)
      StAddr:  limit_m1 = 8'(ADDR_CYCLES - 1);
      StWdata: limit_m1 = 8'(DATA_CYCLES - 1);
      StRdata: limit_m1 = 8'(RD_WAIT - 1);
      default: limit_m1 = 8'd0;
    endcase
  end

  assign last = (cnt_q == limit_m1);

  // The sampling rising edge sits mid-way through the last RDATA gpmc cycle.
  assign rd_sample = (state_q == StRdata) && !gclk_q && last && !rd_done_q && !stall_seen;
  assign rd_done_d = rd_sample ? 1'b1 : ((state_q == StRdata) ? rd_done_q : 1'b0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fall_tick && !stall) begin
      unique case (state_q)
        StIdle:  if (hs) state_d = StAddr;
        StAddr:  if (last) state_d = write_q ? StWdata : StRdata;
        StWdata: if (last) state_d = StTurn;
        StRdata: if (last) state_d = StTurn;
        StTurn:  state_d = hs ? StAddr : StIdle;
        default: state_d = StIdle;
      endcase
      if (state_d != state_q) cnt_d = 8'd0;
      else if (state_q != StIdle) cnt_d = cnt_q + 8'd1;
    end
  end

  assign write_n = hs ? req_write : write_q;
  assign addr_n  = hs ? req_addr : addr_q;
  assign wdata_n = hs ? req_wdata : wdata_q;

  always_comb begin
    addr_ext                    = '0;
    addr_ext[ADDR_WIDTH-1:0]    = addr_n;
    wdata_ext                   = '0;
    wdata_ext[DATA_WIDTH-1:0]   = wdata_n;
    cs_n_d   = 1'b1;
    adv_n_d  = 1'b1;
    we_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    unique case (state_d)
      StAddr: begin
        cs_n_d   = 1'b0;
        adv_n_d  = 1'b0;
        we_n_d   = ~write_n;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_ext;
      end
      StWdata: begin
        cs_n_d   = 1'b0;
        we_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = wdata_ext;
      end
      StRdata: begin
        cs_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gclk_q      <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      rd_done_q   <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_n_q      <= 1'b1;
      adv_n_q     <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      gclk_q      <= ~gclk_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_done_q   <= rd_done_d;
      write_q     <= write_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      rsp_valid_q <= rd_sample;
      wr_done_q   <= fall_tick && (state_q == StWdata) && (state_d == StTurn);
      if (rd_sample) rsp_rdata_q <= gpmc_ad_in[DATA_WIDTH-1:0];
      if (fall_tick) begin
        cs_n_q   <= cs_n_d;
        adv_n_q  <= adv_n_d;
        we_n_q   <= we_n_d;
        oe_n_q   <= oe_n_d;
        ad_oe_q  <= ad_oe_d;
        ad_out_q <= ad_out_d;
      end
    end
  end

  assign gpmc_clk    = gclk_q;
  assign gpmc_cs_n   = cs_n_q;
  assign gpmc_adv_n  = adv_n_q;
  assign gpmc_we_n   = we_n_q;
  assign gpmc_oe_n   = oe_n_q;
  assign gpmc_ad_oe  = ad_oe_q;
  assign gpmc_ad_out = ad_out_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign wr_done     = wr_done_q;

endmodule

// File: doc/gpmc_sync_initiator.md
# gpmc_sync_initiator

Synchronous GPMC initiator: turns host-side read/write requests into muxed address/data GPMC transactions on a forwarded clock. It drives `gpmc_clk`, `cs_n`, `adv_n`, `we_n`, `oe_n` and the AD bus. It is the far end of our FPGA GPMC responder, used for FPGA-to-FPGA links and loopback bring-up of the responder. The tristate pad lives outside the block, which exposes separate out, output-enable and in vectors.

## Interface
- ADDR_WIDTH, 16, request address width; low bits of AD carry it in the address phase
- DATA_WIDTH, 16, data width (≤16)
- ADDR_CYCLES, 2, gpmc clock cycles `adv_n` is held low (≥1)
- DATA_CYCLES, 2, gpmc cycles write data is held (≥1)
- RD_WAIT, 2, gpmc cycles from end of address phase to read-data sample (≥1)

- clk  in  1  system clock; gpmc_clk = clk/2
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&&ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-clk pulse, read data valid
- rsp_rdata  out  DATA_WIDTH  read data
- wr_done  out  1  one-clk pulse, write completed
- gpmc_clk  out  1  forwarded GPMC clock
- gpmc_cs_n, gpmc_adv_n, gpmc_we_n, gpmc_oe_n  out  1 each  GPMC strobes
- gpmc_ad_out  out  16  AD drive value
- gpmc_ad_oe  out  1  AD output enable
- gpmc_ad_in  in  16  AD pad input
- gpmc_wait  in  1  responder stall (see Configuration)

## Operation
- `gpmc_clk` is a register toggling every clk.
- "Fall tick": a clk edge where `gpmc_clk` goes 1→0. All GPMC outputs change only on fall ticks, giving the responder half a gpmc period of setup before its rising-edge sample.
- Reset values: `gpmc_clk`=0; `cs_n`, `adv_n`, `we_n`, `oe_n` all =1; `ad_oe`=0; `ad_out`=0; `req_ready`=0; `rsp_valid`=0; `wr_done`=0; `rsp_rdata`=0.
- States:
  - IDLE: `req_ready`=1 for exactly the clk cycle preceding a fall tick. A handshake captures addr, wdata and write. At that fall tick → ADDR.
  - ADDR: `cs_n`=0, `adv_n`=0, `ad_oe`=1, `ad_out`=addr zero-extended to 16 bits, `we_n`=~write, `oe_n`=1. Held ADDR_CYCLES gpmc cycles. On exit `adv_n`=1. Write → WDATA; read → RDATA.
  - WDATA: `ad_out`=wdata (zero-extended), `we_n`=0. Held DATA_CYCLES gpmc cycles, then → TURN with `wr_done` pulse.
  - RDATA: `ad_oe`=0, `oe_n`=0. At the rising gpmc edge ending the RD_WAIT-th cycle, sample `gpmc_ad_in[DATA_WIDTH-1:0]` into `rsp_rdata` and pulse `rsp_valid`. Next fall tick → TURN.
  - TURN: `cs_n`, `we_n`, `oe_n` all =1; `ad_oe`=0; `ad_out`=0. One gpmc cycle, then IDLE.
- The bus is never driven while `oe_n`=0. `ad_oe` falls on the same fall tick that `oe_n` falls.
- Request inputs are ignored outside the handshake. Only one outstanding transaction at a time.
- Reset asserted mid-transaction: outputs go to reset values asynchronously; no `rsp_valid` or `wr_done` is issued for the aborted transaction.

## Timing
- Handshake to first `cs_n` low: 1 clk, which is the fall tick itself.
- Write: `cs_n` low for (ADDR_CYCLES+DATA_CYCLES) gpmc cycles. `wr_done` is asserted in the clk cycle after the fall tick that raises `cs_n`.
- Read: `rsp_valid` is asserted in the clk cycle after the sampling rising edge, i.e. (ADDR_CYCLES+RD_WAIT) gpmc cycles after `cs_n` falls.
- Back-to-back: next `req_ready` no earlier than the end of TURN. Minimum one gpmc cycle with `cs_n` high between transactions.
- Defaults: write occupies 5 gpmc cycles = 10 clk handshake-to-handshake; read also occupies 5 gpmc cycles.

## Configuration
- `GPMC_INIT_WAIT_EN` defined:
  - `gpmc_wait` is double-flopped in clk and evaluated at fall ticks.
  - While the synchronized `gpmc_wait`=1 in WDATA or RDATA, the cycle count freezes and all outputs hold.
  - The read sample occurs only on a rising edge whose preceding fall tick saw wait=0.
- Undefined: `gpmc_wait` is ignored; timing is fixed by the parameters.

## Test plan
- Reset → all outputs at listed reset values. Release → first `req_ready` within 2 clk.
- Write addr=0x1234 data=0xBEEF, defaults → AD shows 0x1234 with `adv_n`=0 for 2 gpmc cycles, then 0xBEEF with `we_n`=0 for 2; `wr_done` pulses once; `cs_n` high ≥1 gpmc cycle after.
- Read addr=0x0042, responder model drives 0xA5A5 → `ad_oe`=0 while `oe_n`=0; `rsp_rdata`=0xA5A5 with a single `rsp_valid` pulse 4 gpmc cycles after `cs_n` falls.
- Back-to-back write then read with `req_valid` held high → two distinct `cs_n` low windows separated by exactly 1 gpmc cycle; no AD contention.
- `rst_n` pulsed low mid-WDATA → `cs_n`=1 and `ad_oe`=0 immediately; no `wr_done`; the next request completes normally.
- With `GPMC_INIT_WAIT_EN`, `gpmc_wait` high for 3 gpmc cycles during RDATA → `rsp_valid` delayed by exactly 3 gpmc cycles, data correct.
